// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU select codes, sequencer states and instruction classes
package ctrl_pkg;
  localparam logic [3:0] LINK_REG = 4'd15;
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010, OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110, OP_SHR = 5'b00111;
  localparam logic [4:0] OP_SHL = 5'b01000, OP_ROR = 5'b01001, OP_ROL = 5'b01010, OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100, OP_ORI = 5'b01101, OP_MUL = 5'b01110, OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000, OP_NOT = 5'b10001, OP_BR = 5'b10010, OP_JR = 5'b10011;
  localparam logic [4:0] OP_JAL = 5'b10100, OP_IN = 5'b10101, OP_OUT = 5'b10110, OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000, OP_NOP = 5'b11001, OP_HALT = 5'b11010;
  localparam logic [4:0] ALU_NOP = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_AND = 5'd3, ALU_OR = 5'd4;
  localparam logic [4:0] ALU_SHR = 5'd5, ALU_SHL = 5'd6, ALU_ROR = 5'd7, ALU_ROL = 5'd8;
  localparam logic [4:0] ALU_MUL = 5'd9, ALU_DIV = 5'd10, ALU_NEG = 5'd11, ALU_NOT = 5'd12;
  typedef enum logic [3:0] {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_RESET, S_HALT} state_t;
  typedef enum logic [4:0] {C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_UNARY, C_BR, C_JR, C_JAL,
                            C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL} cls_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: opcode -> instruction class, ALU select and final execute step (op in; cls, alu, last out)
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] op,
  output cls_t       cls,
  output logic [4:0] alu,
  output logic [2:0] last
);
  always_comb begin
    cls = C_ILL;
    alu = ALU_NOP;
    case (op)
      OP_LD:   cls = C_LD;
      OP_LDI:  cls = C_LDI;
      OP_ST:   cls = C_ST;
      OP_ADD:  begin cls = C_ALU; alu = ALU_ADD; end
      OP_SUB:  begin cls = C_ALU; alu = ALU_SUB; end
      OP_AND:  begin cls = C_ALU; alu = ALU_AND; end
      OP_OR:   begin cls = C_ALU; alu = ALU_OR; end
      OP_SHR:  begin cls = C_ALU; alu = ALU_SHR; end
      OP_SHL:  begin cls = C_ALU; alu = ALU_SHL; end
      OP_ROR:  begin cls = C_ALU; alu = ALU_ROR; end
      OP_ROL:  begin cls = C_ALU; alu = ALU_ROL; end
      OP_ADDI: begin cls = C_IMM; alu = ALU_ADD; end
      OP_ANDI: begin cls = C_IMM; alu = ALU_AND; end
      OP_ORI:  begin cls = C_IMM; alu = ALU_OR; end
      OP_MUL:  begin cls = C_MULDIV; alu = ALU_MUL; end
      OP_DIV:  begin cls = C_MULDIV; alu = ALU_DIV; end
      OP_NEG:  begin cls = C_UNARY; alu = ALU_NEG; end
      OP_NOT:  begin cls = C_UNARY; alu = ALU_NOT; end
      OP_BR:   cls = C_BR;
      OP_JR:   cls = C_JR;
      OP_JAL:  cls = C_JAL;
      OP_IN:   cls = C_IN;
      OP_OUT:  cls = C_OUT;
      OP_MFHI: cls = C_MFHI;
      OP_MFLO: cls = C_MFLO;
      OP_NOP:  cls = C_NOP;
      OP_HALT: cls = C_HALT;
      default: cls = C_ILL;
    endcase
    case (cls)
      C_LD, C_ST:                          last = 3'd7;
      C_LDI, C_ALU, C_IMM:                 last = 3'd5;
      C_MULDIV, C_BR:                      last = 3'd6;
      C_UNARY, C_JAL:                      last = 3'd4;
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO:   last = 3'd3;
      default:                             last = 3'd2;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit driving the CPU datapath strobes
// Inputs clk, clr (async reset), IR, CON_FF_Out, stop; outputs run, datapath strobes, ALUSelection.
// CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt and raise the sticky illegal_op output.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF_Out,
  input  logic        stop,
  output logic        run,
  output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, wren, IRin,
  output logic        Yin, Zin, ZLOout, ZHIout, HIin, HIout, Loin, Loout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, InPortout, OPin, CON_FF_In,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic        illegal_op,
`endif
  output logic [4:0]  ALUSelection
);
  state_t state, nxt;
  cls_t cls;
  logic [4:0] alu;
  logic [2:0] last;
  logic [3:0] hold_cnt;
  logic paused, pause_now, hold_done, to_halt, unused_ir;
  ctrl_decode u_dec (.op(IR[31:27]), .cls(cls), .alu(alu), .last(last));
  assign unused_ir = ^IR[26:0];
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign to_halt = cls == C_HALT || cls == C_ILL;
  always_ff @(posedge clk or posedge clr)
    if (clr) illegal_op <= 1'b0;
    else if (state == S_T2 && cls == C_ILL) illegal_op <= 1'b1;
`else
  assign to_halt = cls == C_HALT;
`endif
  assign hold_done = int'(hold_cnt) >= RESET_PC_HOLD - 1;
  // A paused sequencer keeps its finished state; leaving the pause always means a fresh fetch.
  assign nxt = state == S_HALT ? S_HALT :
               state == S_RESET ? (hold_done ? S_T0 : S_RESET) :
               (state == S_T2 && to_halt) ? S_HALT :
               (paused || state[2:0] == last) ? S_T0 : state_t'(state + 4'd1);
  assign pause_now = nxt == S_T0 && stop;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= S_RESET;
      paused <= 1'b0;
      hold_cnt <= '0;
    end else begin
      paused <= pause_now;
      state <= pause_now ? state : nxt;
      hold_cnt <= (state == S_RESET && !hold_done) ? hold_cnt + 4'd1 : hold_cnt;
    end
  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, wren, IRin, Yin, Zin, ZLOout, ZHIout, HIin,
     HIout, Loin, Loout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, InPortout, OPin, CON_FF_In} = '0;
    ALUSelection = ALU_NOP;
    run = !paused && state != S_RESET && state != S_HALT;
    if (!paused)
      case (state)
        S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
        S_T1: begin ZLOout = 1'b1; PCin = 1'b1; MDRread = 1'b1; MDRin = 1'b1; end
        S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
        S_T3:
          case (cls)
            C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            C_ALU, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            C_MULDIV:          begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            C_UNARY:           begin Grb = 1'b1; Rout = 1'b1; ALUSelection = alu; Zin = 1'b1; end
            C_BR:              begin Gra = 1'b1; Rout = 1'b1; CON_FF_In = 1'b1; end
            C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            C_JAL:             begin Grb = 1'b1; Rin = 1'b1; PCout = 1'b1; end
            C_IN:              begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_OUT:             begin Gra = 1'b1; Rout = 1'b1; OPin = 1'b1; end
            C_MFHI:            begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_MFLO:            begin Loout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        S_T4:
          case (cls)
            C_LD, C_LDI, C_ST: begin Cout = 1'b1; ALUSelection = ALU_ADD; Zin = 1'b1; end
            C_ALU:             begin Grc = 1'b1; Rout = 1'b1; ALUSelection = alu; Zin = 1'b1; end
            C_IMM:             begin Cout = 1'b1; ALUSelection = alu; Zin = 1'b1; end
            C_MULDIV:          begin Grb = 1'b1; Rout = 1'b1; ALUSelection = alu; Zin = 1'b1; end
            C_UNARY:           begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
            C_JAL:             begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default: ;
          endcase
        S_T5:
          case (cls)
            C_LD, C_ST:          begin ZLOout = 1'b1; MARin = 1'b1; end
            C_LDI, C_ALU, C_IMM: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_MULDIV:            begin ZLOout = 1'b1; Loin = 1'b1; end
            C_BR:                begin Cout = 1'b1; ALUSelection = ALU_ADD; Zin = 1'b1; end
            default: ;
          endcase
        S_T6:
          case (cls)
            C_LD:     begin MDRread = 1'b1; MDRin = 1'b1; end
            C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            C_MULDIV: begin ZHIout = 1'b1; HIin = 1'b1; end
            C_BR:     begin ZLOout = 1'b1; PCin = CON_FF_Out; end
            default: ;
          endcase
        S_T7:
          case (cls)
            C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_ST:    wren = 1'b1;
            default: ;
          endcase
        default: ;
      endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed stimulus against a step-table model of the control sequencer
module tb_control_sequencer;
  import ctrl_pkg::*;
  localparam int HOLD = 1;
  localparam logic [26:0] PCOUT = 27'd1 << 0, PCIN = 27'd1 << 1, INCPC = 27'd1 << 2, MARIN = 27'd1 << 3;
  localparam logic [26:0] MDRIN = 27'd1 << 4, MDROUT = 27'd1 << 5, MDRREAD = 27'd1 << 6, WREN = 27'd1 << 7;
  localparam logic [26:0] IRIN = 27'd1 << 8, YIN = 27'd1 << 9, ZIN = 27'd1 << 10, ZLO = 27'd1 << 11;
  localparam logic [26:0] ZHI = 27'd1 << 12, HIIN = 27'd1 << 13, HIOUT = 27'd1 << 14, LOIN = 27'd1 << 15;
  localparam logic [26:0] LOOUT = 27'd1 << 16, GRA = 27'd1 << 17, GRB = 27'd1 << 18, GRC = 27'd1 << 19;
  localparam logic [26:0] RIN = 27'd1 << 20, ROUT = 27'd1 << 21, BAOUT = 27'd1 << 22, COUT = 27'd1 << 23;
  localparam logic [26:0] INP = 27'd1 << 24, OPIN = 27'd1 << 25, CONIN = 27'd1 << 26;
  localparam logic [26:0] FETCH0 = PCOUT | MARIN | INCPC | ZIN;
  logic clk = 1'b0, clr = 1'b1, con = 1'b0, stop = 1'b0;
  logic [31:0] ir = 32'h0;
  logic run, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, wren, IRin, Yin, Zin, ZLOout, ZHIout;
  logic HIin, HIout, Loin, Loout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, InPortout, OPin, CON_FF_In;
  logic [4:0] alu_sel;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_op;
`endif
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(ir), .CON_FF_Out(con), .stop(stop), .run(run),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .MDRread(MDRread), .wren(wren), .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZLOout(ZLOout),
    .ZHIout(ZHIout), .HIin(HIin), .HIout(HIout), .Loin(Loin), .Loout(Loout), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .InPortout(InPortout),
    .OPin(OPin), .CON_FF_In(CON_FF_In),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .ALUSelection(alu_sel)
  );
  wire [26:0] dv = {CON_FF_In, OPin, InPortout, Cout, BAout, Rout, Rin, Grc, Grb, Gra, Loout, Loin,
                    HIout, HIin, ZHIout, ZLOout, Zin, Yin, IRin, wren, MDRread, MDRout, MDRin, MARin,
                    IncPC, PCin, PCout};
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [4:0] alu_of(input logic [4:0] o);
    case (o)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_SHR:          return ALU_SHR;
      OP_SHL:          return ALU_SHL;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_NOP;
    endcase
  endfunction
  function automatic int exec_len(input logic [4:0] o);
    case (o)
      OP_LD, OP_ST: return 5;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI: return 3;
      OP_MUL, OP_DIV, OP_BR: return 4;
      OP_NEG, OP_NOT, OP_JAL: return 2;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: return 1;
      default: return 0;
    endcase
  endfunction
  function automatic bit halts(input logic [4:0] o);
`ifdef CTRL_ILLEGAL_TRAP_EN
    return o >= OP_HALT;
`else
    return o == OP_HALT;
`endif
  endfunction
  function automatic logic [26:0] fetch(input int k);
    return k == 0 ? FETCH0 : k == 1 ? (ZLO | PCIN | MDRREAD | MDRIN) : (MDROUT | IRIN);
  endfunction
  // {ALUSelection, strobes} for execute step j (j = 0 is T3) of opcode o
  function automatic logic [31:0] step(input logic [4:0] o, input int j, input logic c);
    logic [26:0] m = '0;
    logic [4:0] a = ALU_NOP;
    case (o)
      OP_LD, OP_LDI, OP_ST:
        case (j)
          0: m = GRB | BAOUT | YIN;
          1: begin m = COUT | ZIN; a = ALU_ADD; end
          2: m = o == OP_LDI ? (ZLO | GRA | RIN) : (ZLO | MARIN);
          3: m = o == OP_LD ? (MDRREAD | MDRIN) : (GRA | ROUT | MDRIN);
          default: m = o == OP_LD ? (MDROUT | GRA | RIN) : WREN;
        endcase
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI:
        case (j)
          0: m = GRB | ROUT | YIN;
          1: begin m = (o >= OP_ADDI ? COUT : (GRC | ROUT)) | ZIN; a = alu_of(o); end
          default: m = ZLO | GRA | RIN;
        endcase
      OP_MUL, OP_DIV:
        case (j)
          0: m = GRA | ROUT | YIN;
          1: begin m = GRB | ROUT | ZIN; a = alu_of(o); end
          2: m = ZLO | LOIN;
          default: m = ZHI | HIIN;
        endcase
      OP_NEG, OP_NOT:
        if (j == 0) begin m = GRB | ROUT | ZIN; a = alu_of(o); end
        else m = ZLO | GRA | RIN;
      OP_BR:
        case (j)
          0: m = GRA | ROUT | CONIN;
          1: m = PCOUT | YIN;
          2: begin m = COUT | ZIN; a = ALU_ADD; end
          default: m = ZLO | (c ? PCIN : 27'd0);
        endcase
      OP_JR:   m = GRA | ROUT | PCIN;
      OP_JAL:  m = j == 0 ? (GRB | RIN | PCOUT) : (GRA | ROUT | PCIN);
      OP_IN:   m = INP | GRA | RIN;
      OP_OUT:  m = GRA | ROUT | OPIN;
      OP_MFHI: m = HIOUT | GRA | RIN;
      OP_MFLO: m = LOOUT | GRA | RIN;
      default: m = '0;
    endcase
    return {a, m};
  endfunction
  typedef enum {MD_RST, MD_RUN, MD_PAUSE, MD_HALT} mode_t;
  mode_t m_mode = MD_RST;
  int m_k = 0, m_hold = 0;
  wire [4:0] op = ir[31:27];
  always @(posedge clk or posedge clr)
    if (clr) begin
      m_mode <= MD_RST; m_hold <= 0; m_k <= 0;
    end else
      case (m_mode)
        MD_RST:
          if (m_hold >= HOLD - 1) begin m_mode <= stop ? MD_PAUSE : MD_RUN; m_k <= 0; end
          else m_hold <= m_hold + 1;
        MD_RUN:
          if (m_k == 2 && halts(op)) m_mode <= MD_HALT;
          else if (m_k == 2 + exec_len(op)) begin m_mode <= stop ? MD_PAUSE : MD_RUN; m_k <= 0; end
          else m_k <= m_k + 1;
        MD_PAUSE:
          if (!stop) begin m_mode <= MD_RUN; m_k <= 0; end
        default: ;
      endcase
  wire [31:0] m_exp = m_mode != MD_RUN ? 32'd0 : m_k < 3 ? {5'd0, fetch(m_k)} : step(op, m_k - 3, con);
  always @(negedge clk) begin
    check("model_strobes", {alu_sel, dv}, m_exp);
    check("model_run", {31'd0, run}, {31'd0, m_mode == MD_RUN});
  end
  task automatic sync_t0();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #2;
      ok = m_mode == MD_RUN && m_k == 0;
    end
    check("sync_t0", {31'd0, ok}, 32'd1);
  endtask
  task automatic instr(input logic [31:0] i, input logic c);
    sync_t0();
    ir = i;
    con = c;
  endtask
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk); #1;
  endtask
  logic [4:0] ops [21] = '{OP_LDI, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ADDI, OP_ANDI,
                           OP_ORI, OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP};
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    ir = 32'hC8000000;
    repeat (3) @(negedge clk);
    #1 check("clr_run", {31'd0, run}, 32'd0);
    check("clr_strobes", {alu_sel, dv}, 32'd0);
    @(posedge clk); #2 clr = 1'b0;
    adv(0);
    check("reset_hold_run", {31'd0, run}, 32'd0);
    check("reset_hold_strobes", {5'd0, dv}, 32'd0);
    adv(1);
    check("t0_strobes", {5'd0, dv}, {5'd0, FETCH0});
    check("t0_run", {31'd0, run}, 32'd1);
    instr(32'h01000044, 1'b0);
    adv(3); check("ld_t3", {5'd0, dv}, {5'd0, GRB | BAOUT | YIN});
    adv(1); check("ld_t4", {alu_sel, dv}, {ALU_ADD, COUT | ZIN});
    adv(1); check("ld_t5", {5'd0, dv}, {5'd0, ZLO | MARIN});
    adv(1); check("ld_t6", {5'd0, dv}, {5'd0, MDRREAD | MDRIN});
    adv(1); check("ld_t7", {5'd0, dv}, {5'd0, MDROUT | GRA | RIN});
    adv(1); check("ld_next_t0", {5'd0, dv}, {5'd0, FETCH0});
    instr(32'hA1000000, 1'b0);
    adv(3); check("jal_t3", {5'd0, dv}, {5'd0, GRB | RIN | PCOUT});
    adv(1); check("jal_t4", {5'd0, dv}, {5'd0, GRA | ROUT | PCIN});
    adv(1); check("jal_next_t0", {5'd0, dv}, {5'd0, FETCH0});
    instr(32'h90000000, 1'b0);
    adv(6); check("br_t6_pcin0", {30'd0, PCin, ZLOout}, 32'd1);
    instr(32'h90000000, 1'b1);
    adv(6); check("br_t6_pcin1", {30'd0, PCin, ZLOout}, 32'd3);
    foreach (ops[i]) instr({ops[i], 27'd0}, ops[i][0]);
    instr(32'h70000000, 1'b0);
    adv(6); check("mul_t6", {5'd0, dv}, {5'd0, ZHI | HIIN});
`ifndef CTRL_ILLEGAL_TRAP_EN
    instr(32'hD8000000, 1'b0);
    adv(3); check("undef_as_nop", {5'd0, dv}, {5'd0, FETCH0});
    instr(32'hF8000000, 1'b0);
`endif
    instr(32'h18000000, 1'b0);
    adv(4); check("add_t4", {alu_sel, dv}, {ALU_ADD, GRC | ROUT | ZIN});
    adv(1); check("add_t5", {5'd0, dv}, {5'd0, ZLO | GRA | RIN});
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adv(1);
      check("pause_strobes", {alu_sel, dv}, 32'd0);
      check("pause_run", {31'd0, run}, 32'd0);
    end
    stop = 1'b0;
    adv(1); check("resume_t0", {5'd0, dv}, {5'd0, FETCH0});
    check("resume_run", {31'd0, run}, 32'd1);
    instr(32'h10000000, 1'b0);
    adv(4); check("st_t4", {alu_sel, dv}, {ALU_ADD, COUT | ZIN});
    clr = 1'b1;
    #1 check("clr_async_strobes", {alu_sel, dv}, 32'd0);
    check("clr_async_run", {31'd0, run}, 32'd0);
    ir = 32'hC8000000;
    for (int i = 0; i < 4; i++) begin
      adv(1);
      check("clr_no_wren", {31'd0, wren}, 32'd0);
    end
    @(posedge clk); #2 clr = 1'b0;
    instr(32'hD0000000, 1'b0);
    adv(3);
    for (int i = 0; i < 20; i++) begin
      check("halt_run", {31'd0, run}, 32'd0);
      check("halt_strobes", {alu_sel, dv}, 32'd0);
      if (i == 5) ir = 32'hC8000000;
      adv(1);
    end
    clr = 1'b1;
    @(posedge clk); #2 clr = 1'b0;
    sync_t0();
    adv(0); check("restart_t0", {5'd0, dv}, {5'd0, FETCH0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
